// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALUOp encodings and
// the decoded control bundle carried from ID into EX.
package riscv_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10
   } alu_op_e;

   // Any zeroed instance of this struct is architecturally inert.
   typedef struct packed {
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic branch;
   } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side registered outputs of the ID/EX pipeline register.
interface id_ex_stage_if #(
   parameter int XLEN = riscv_pkg::XLEN_DEF
);
   logic            id_valid;
   logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic            id_uses_rs1, id_uses_rs2;
   logic [1:0]      id_alu_op;
   logic [6:0]      id_funct7;
   logic [2:0]      id_funct3;
   logic            id_alu_src, id_mem_read, id_mem_write;
   logic            id_reg_write, id_mem_to_reg, id_branch;
   logic            ex_flush;

   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic            ex_uses_rs1, ex_uses_rs2;
   logic [1:0]      ex_alu_op;
   logic [6:0]      ex_funct7;
   logic [2:0]      ex_funct3;
   logic            ex_alu_src, ex_mem_read, ex_mem_write;
   logic            ex_reg_write, ex_mem_to_reg, ex_branch;
   logic            stall_id;
   logic [15:0]     stall_count;

   modport master (
      output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
             id_uses_rs1, id_uses_rs2, id_alu_op, id_funct7, id_funct3,
             id_alu_src, id_mem_read, id_mem_write, id_reg_write,
             id_mem_to_reg, id_branch, ex_flush,
      input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_uses_rs1, ex_uses_rs2, ex_alu_op, ex_funct7, ex_funct3,
             ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
             ex_mem_to_reg, ex_branch, stall_id, stall_count
   );

   modport slave (
      input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
             id_uses_rs1, id_uses_rs2, id_alu_op, id_funct7, id_funct3,
             id_alu_src, id_mem_read, id_mem_write, id_reg_write,
             id_mem_to_reg, id_branch, ex_flush,
      output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_uses_rs1, ex_uses_rs2, ex_alu_op, ex_funct7, ex_funct3,
             ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
             ex_mem_to_reg, ex_branch, stall_id, stall_count
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect (
   input  logic       id_valid_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       ex_valid_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_flush_i,
   output logic       stall_o
);
   logic src_match;
   logic hazard;

   // x0 is never a real producer, so a load targeting it cannot create a dependency.
   assign src_match = (id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_uses_rs2_i && (id_rs2_i == ex_rd_i));
   assign hazard    = id_valid_i && ex_valid_i && ex_mem_read_i &&
                      (ex_rd_i != 5'd0) && src_match;
   assign stall_o   = hazard && !ex_flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating count of inserted load-use bubbles.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            uses_rs1;
      logic            uses_rs2;
      alu_op_e         alu_op;
      logic [6:0]      funct7;
      logic [2:0]      funct3;
      id_ex_ctrl_t     ctrl;
   } ex_reg_t;

   ex_reg_t     ex_q, ex_d;
   id_ex_ctrl_t id_ctrl;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall;

   hazard_detect u_hazard (
      .id_valid_i    (bus.id_valid),
      .id_uses_rs1_i (bus.id_uses_rs1),
      .id_uses_rs2_i (bus.id_uses_rs2),
      .id_rs1_i      (bus.id_rs1),
      .id_rs2_i      (bus.id_rs2),
      .ex_valid_i    (ex_q.valid),
      .ex_mem_read_i (ex_q.ctrl.mem_read),
      .ex_rd_i       (ex_q.rd),
      .ex_flush_i    (bus.ex_flush),
      .stall_o       (stall)
   );

   // An empty ID slot must not carry live controls into EX.
   always_comb begin
      id_ctrl            = '0;
      id_ctrl.alu_src    = bus.id_alu_src;
      id_ctrl.mem_read   = bus.id_mem_read;
      id_ctrl.mem_write  = bus.id_mem_write;
      id_ctrl.reg_write  = bus.id_reg_write;
      id_ctrl.mem_to_reg = bus.id_mem_to_reg;
      id_ctrl.branch     = bus.id_branch;
      if (!bus.id_valid) id_ctrl = '0;
   end

   // Flush outranks stall; both load a fully zeroed bubble.
   always_comb begin
      ex_d          = '0;
      ex_d.valid    = bus.id_valid;
      ex_d.pc       = bus.id_pc;
      ex_d.rd1      = bus.id_rd1;
      ex_d.rd2      = bus.id_rd2;
      ex_d.imm      = bus.id_imm;
      ex_d.rs1      = bus.id_rs1;
      ex_d.rs2      = bus.id_rs2;
      ex_d.rd       = bus.id_rd;
      ex_d.uses_rs1 = bus.id_uses_rs1;
      ex_d.uses_rs2 = bus.id_uses_rs2;
      ex_d.alu_op   = alu_op_e'(bus.id_alu_op);
      ex_d.funct7   = bus.id_funct7;
      ex_d.funct3   = bus.id_funct3;
      ex_d.ctrl     = id_ctrl;
      if (bus.ex_flush || stall) ex_d = '0;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_pc         = ex_q.pc;
   assign bus.ex_rd1        = ex_q.rd1;
   assign bus.ex_rd2        = ex_q.rd2;
   assign bus.ex_imm        = ex_q.imm;
   assign bus.ex_rs1        = ex_q.rs1;
   assign bus.ex_rs2        = ex_q.rs2;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_uses_rs1   = ex_q.uses_rs1;
   assign bus.ex_uses_rs2   = ex_q.uses_rs2;
   assign bus.ex_alu_op     = ex_q.alu_op;
   assign bus.ex_funct7     = ex_q.funct7;
   assign bus.ex_funct3     = ex_q.funct3;
   assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
   assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
   assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
   assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
   assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
   assign bus.ex_branch     = ex_q.ctrl.branch;
   assign bus.stall_id      = stall;
   assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX snapshots, one per clock.
module tb_id_ex_stage;
   localparam int XLEN = 32;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [1:0]  alu_op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [5:0]  ctrl;   // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
      logic [15:0] cnt;
   } snap_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   npass = 0;
   int   ntotal = 0;
   snap_t m;
   snap_t sb[$];

   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(XLEN)) bus ();
   id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic snap_t observe();
      snap_t s;
      s.valid = bus.ex_valid;  s.pc = bus.ex_pc;   s.rd1 = bus.ex_rd1;
      s.rd2 = bus.ex_rd2;      s.imm = bus.ex_imm; s.rs1 = bus.ex_rs1;
      s.rs2 = bus.ex_rs2;      s.rd = bus.ex_rd;   s.u1 = bus.ex_uses_rs1;
      s.u2 = bus.ex_uses_rs2;  s.alu_op = bus.ex_alu_op;
      s.f7 = bus.ex_funct7;    s.f3 = bus.ex_funct3;
      s.ctrl = {bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_branch};
      s.cnt = bus.stall_count;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, rd1, rd2, imm,
                         input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                         input logic [1:0] aop, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [5:0] c);
      bus.id_valid = v;  bus.id_pc = pc;   bus.id_rd1 = rd1; bus.id_rd2 = rd2;
      bus.id_imm = imm;  bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
      bus.id_alu_op = aop;  bus.id_funct7 = f7; bus.id_funct3 = f3;
      {bus.id_alu_src, bus.id_mem_read, bus.id_mem_write,
       bus.id_reg_write, bus.id_mem_to_reg, bus.id_branch} = c;
   endtask

   task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
      set_id(1'b1, pc, 32'h1000, 32'h0, 32'h8, rs1, 5'd0, rd, 1'b1, 1'b0,
             2'b00, 7'h00, 3'b010, 6'b110110);
   endtask

   task automatic alu(input logic [4:0] rd, rs1, rs2, input logic u1, u2, input logic [31:0] pc);
      set_id(1'b1, pc, 32'hA0 + pc, 32'hB0 + pc, 32'h0, rs1, rs2, rd, u1, u2,
             2'b10, 7'h00, 3'b000, 6'b000100);
   endtask

   // Predict stall_id and the next EX snapshot, clock once, compare both.
   task automatic step(input string tag);
      snap_t e;
      logic  hz, st;
      #1;
      hz = bus.id_valid && m.valid && m.ctrl[4] && (m.rd != 5'd0) &&
           ((bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd));
      st = hz && !bus.ex_flush;
      chk({tag, "_stall"}, 256'(bus.stall_id), 256'(st));
      e = '0;
      e.cnt = m.cnt;
      if (bus.ex_flush || st) begin
         if (st && m.cnt != 16'hFFFF) e.cnt = m.cnt + 16'd1;
      end else begin
         e.valid = bus.id_valid; e.pc = bus.id_pc; e.rd1 = bus.id_rd1;
         e.rd2 = bus.id_rd2; e.imm = bus.id_imm; e.rs1 = bus.id_rs1;
         e.rs2 = bus.id_rs2; e.rd = bus.id_rd; e.u1 = bus.id_uses_rs1;
         e.u2 = bus.id_uses_rs2; e.alu_op = bus.id_alu_op;
         e.f7 = bus.id_funct7; e.f3 = bus.id_funct3;
         e.ctrl = bus.id_valid ? {bus.id_alu_src, bus.id_mem_read, bus.id_mem_write,
                                  bus.id_reg_write, bus.id_mem_to_reg, bus.id_branch} : 6'b0;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      m = e;
      chk({tag, "_ex"}, 256'(observe()), 256'(e));
   endtask

   initial begin
      bus.ex_flush = 1'b0;
      set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
             2'b00, 7'h00, 3'b000, 6'b0);
      m = '0;
      #3;
      chk("reset_state", 256'(observe()), 256'(0));
      chk("reset_stall", 256'(bus.stall_id), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ADD x3,x1,x2 then SUB with funct7 0100000
      set_id(1'b1, 32'h100, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1,
             2'b10, 7'h00, 3'b000, 6'b000100);
      step("add_adv");
      set_id(1'b1, 32'h104, 32'hDEADBEEF, 32'h5, 32'h0, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1,
             2'b10, 7'h20, 3'b000, 6'b000100);
      step("sub_adv");

      // reset mid-cycle with a valid instruction in EX
      #2 rst_n = 1'b0;
      #1;
      m = '0;
      chk("async_reset", 256'(observe()), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // load-use on rs2, then the consumer advances
      load(5'd5, 5'd1, 32'h200);       step("lw_x5");
      alu(5'd6, 5'd4, 5'd5, 1'b1, 1'b1, 32'h204); step("loaduse");
      step("after_bubble");

      // no false stall: lw x0, and a consumer that does not read rs2
      load(5'd0, 5'd1, 32'h300);       step("lw_x0");
      alu(5'd6, 5'd0, 5'd2, 1'b1, 1'b0, 32'h304); step("x0_nostall");
      load(5'd5, 5'd1, 32'h308);       step("lw_x5b");
      alu(5'd6, 5'd1, 5'd5, 1'b1, 1'b0, 32'h30C); step("nors2_nostall");

      // back-to-back dependent loads each stall once
      load(5'd5, 5'd1, 32'h400);       step("b2b_lw1");
      load(5'd6, 5'd5, 32'h404);       step("b2b_stall1");
      step("b2b_lw2");
      alu(5'd7, 5'd6, 5'd2, 1'b1, 1'b1, 32'h408); step("b2b_stall2");
      step("b2b_add");

      // flush beats a simultaneous hazard; plain flush also bubbles
      load(5'd5, 5'd1, 32'h500);       step("fl_lw");
      alu(5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 32'h504);
      bus.ex_flush = 1'b1;             step("flush_vs_stall");
      alu(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 32'h508); step("flush_plain");
      bus.ex_flush = 1'b0;

      // empty ID slot must not carry live side-effect controls
      set_id(1'b0, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1,
             2'b10, 7'h00, 3'b000, 6'b111111);
      step("invalid_adv");

      // reset asserted while a stall is pending
      load(5'd5, 5'd1, 32'h700);       step("rs_lw");
      alu(5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 32'h704);
      #1;
      chk("rs_stall_pending", 256'(bus.stall_id), 256'(1));
      rst_n = 1'b0;
      #1;
      m = '0;
      chk("rs_abort_state", 256'(observe()), 256'(0));
      chk("rs_abort_stall", 256'(bus.stall_id), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step("rs_first_adv");

      // saturation: preload FFFE, then two stalls
      set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
             2'b00, 7'h00, 3'b000, 6'b0);
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.stall_cnt_q;
      m = '0;
      m.cnt = 16'hFFFE;
      chk("sat_preload", 256'(bus.stall_count), 256'(16'hFFFE));
      load(5'd5, 5'd1, 32'h800);       step("sat_lw1");
      alu(5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 32'h804); step("sat_stall1");
      load(5'd5, 5'd1, 32'h808);       step("sat_lw2");
      alu(5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 32'h80C); step("sat_stall2");
      chk("sat_final", 256'(bus.stall_count), 256'(16'hFFFF));

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operands, immediate.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port id_valid  input  1  ID holds a real instruction.
REQ-005 SHALL have ports id_pc, id_rd1, id_rd2, id_imm  input  XLEN each  PC, register-file reads, immediate.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-007 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  instruction reads that source.
REQ-008 SHALL have ports id_alu_op 2, id_funct7 7, id_funct3 3  input  ALU controller inputs.
REQ-009 SHALL have ports id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  input  1 each  decoded controls.
REQ-010 SHALL have port ex_flush  input  1  taken branch/jump resolved in EX; kill ID and EX.
REQ-011 SHALL have outputs ex_valid plus ex_<field> for every id_ field of REQ-005..REQ-009, same widths, registered.
REQ-012 SHALL have port stall_id  output  1  combinational; hold PC and IF/ID this cycle.
REQ-013 SHALL have port stall_count  output  16  saturating count of load-use bubbles inserted.

Function
REQ-014 Hazard SHALL be: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-015 stall_id SHALL equal hazard & ~ex_flush.
REQ-016 Priority per edge SHALL be flush > stall > advance.
REQ-017 Flush: ex_valid<=0, all ex_ controls and ex_alu_op/funct fields <=0; stall_count unchanged.
REQ-018 Stall: bubble inserted exactly as flush; stall_count increments by 1, saturating at 16'hFFFF (no wrap).
REQ-019 Advance: every ex_ field <= its id_ field, ex_valid <= id_valid, latency exactly 1 cycle.
REQ-020 Bubble and id_valid=0 advance SHALL both present ex_mem_write=ex_reg_write=ex_branch=0, so no architectural side effect.
REQ-021 Data fields (ex_pc, ex_rd1, ex_rd2, ex_imm, indices) SHALL be zeroed on bubble/flush.
REQ-022 A load with ex_rd=0 SHALL never stall; a stall SHALL last exactly 1 cycle per load (after the bubble ex_valid=0, hazard clears).
REQ-023 Back-to-back loads each feeding the next SHALL each produce one independent stall.
REQ-024 Flush and hazard in same cycle: stall_id=0, no stall_count increment.

Reset
REQ-025 While rst_n=0, all ex_ outputs, ex_valid and stall_count SHALL be 0 immediately (asynchronous), hence stall_id=0.
REQ-026 Deassertion SHALL take effect at the next rising clk; first edge after release performs normal advance.
REQ-027 Reset asserted mid-stall SHALL abort the stall with no held state surviving.

Structure
REQ-028 A shared package riscv_pkg SHALL hold XLEN default, ALUOp encodings (ADD 2'b00, SUB 2'b01, RTYPE 2'b10), and an id_ex_ctrl_t packed struct of the six control bits.
REQ-029 Hazard logic of REQ-014 SHALL be sub-module hazard_detect (purely combinational); registers live in id_ex_stage.

Verification
REQ-030 Reset: rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 before next edge, stall_count=0.
REQ-031 Advance: id ADD x3,x1,x2 (alu_op 10, funct7 0000000, funct3 000, reg_write 1) -> next cycle identical ex_ fields, ex_valid=1.
REQ-032 Load-use: EX lw x5 (mem_read 1, rd 5), ID add using rs2=5 -> stall_id=1, next cycle ex_valid=0, controls 0, stall_count=1; following cycle add advances.
REQ-033 No false stall: EX lw x0, ID uses rs1=0; or ID uses_rs2=0 with rs2=5 -> stall_id=0.
REQ-034 Flush vs stall: hazard and ex_flush=1 same cycle -> stall_id=0, bubble, stall_count unchanged.
REQ-035 Saturation: preload 16'hFFFE via 2 further forced stalls -> stall_count ends at 16'hFFFF, not 0.
